// File: rtl/bubble_pop_engine.sv
// bubble_pop_engine: flood-fill pop stage for the bubble game.
// A shot snapshots the grid, grows a same-colour region from the shot cell
// over 4-adjacent bubbles, and clears it when it holds at least MIN_POP cells.
// Optional feature macro: BUBBLE_DROP_FLOAT_EN. When defined, bubbles no
// longer connected to row 0 after a successful pop are cleared as well.
module bubble_pop_engine #(
  parameter int COLS    = 8,
  parameter int ROWS    = 4,
  parameter int CW      = 5,
  parameter int EMPTY   = 31,
  parameter int MIN_POP = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(ROWS)-1:0]           shoot_row,
  input  logic [$clog2(COLS)-1:0]           shoot_col,
  input  logic [ROWS*COLS*CW-1:0]           grid_in,
  output logic [ROWS*COLS*CW-1:0]           grid_out,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(ROWS*COLS+1)-1:0]    pop_count
);

  localparam int N     = ROWS * COLS;
  localparam int GW    = N * CW;
  localparam int RW    = $clog2(ROWS);
  localparam int CLW   = $clog2(COLS);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CW-1:0] EMPTY_C = CW'(EMPTY);

  // One bit per cell, set for every cell in column c.
  function automatic logic [N-1:0] col_mask(input int c);
    logic [N-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++) m[r*COLS+c] = 1'b1;
    return m;
  endfunction

  localparam logic [N-1:0] COL_FIRST = col_mask(0);
  localparam logic [N-1:0] COL_LAST  = col_mask(COLS - 1);

  // Cells 4-adjacent to any set bit; the column masks stop horizontal
  // shifts from wrapping from the end of one row into the next.
  function automatic logic [N-1:0] grow(input logic [N-1:0] m);
    return (m << COLS) | (m >> COLS)
         | ((m << 1) & ~COL_FIRST)
         | ((m >> 1) & ~COL_LAST);
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(input logic [N-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CNT_W'(m[i]);
    return c;
  endfunction

  // Cells whose colour equals col.
  function automatic logic [N-1:0] match_color(input logic [GW-1:0] g,
                                               input logic [CW-1:0] col);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (g[i*CW +: CW] == col);
    return m;
  endfunction

  // Grid with every masked cell replaced by the empty code.
  function automatic logic [GW-1:0] clear_cells(input logic [GW-1:0] g,
                                                input logic [N-1:0]  m);
    logic [GW-1:0] r;
    r = g;
    for (int i = 0; i < N; i++) if (m[i]) r[i*CW +: CW] = EMPTY_C;
    return r;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXPAND,
    S_COUNT,
    S_APPLY,
    S_DONE
`ifdef BUBBLE_DROP_FLOAT_EN
    ,
    S_ANCHOR,
    S_FLOOD
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    snap_q,  snap_d;
  logic [RW-1:0]    row_q,   row_d;
  logic [CLW-1:0]   col_q,   col_d;
  logic [N-1:0]     match_q, match_d;
  logic [N-1:0]     mark_q,  mark_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [GW-1:0]    grid_q,  grid_d;
  logic [CNT_W-1:0] pop_q,   pop_d;

  logic             in_range;
  int               idx;
  logic [CW-1:0]    target;
  logic [N-1:0]     next_mark;

  // Shot-cell lookup and one growth step of the current mask.
  always_comb begin
    in_range  = (int'(row_q) < ROWS) && (int'(col_q) < COLS);
    idx       = in_range ? (int'(row_q) * COLS + int'(col_q)) : 0;
    target    = snap_q[idx*CW +: CW];
    next_mark = mark_q | (grow(mark_q) & match_q);
  end

  // Next-state and datapath updates for the pop sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves one unassigned (no latches).
    state_d = state_q;
    snap_d  = snap_q;
    row_d   = row_q;
    col_d   = col_q;
    match_d = match_q;
    mark_d  = mark_q;
    cnt_d   = cnt_q;
    grid_d  = grid_q;
    pop_d   = pop_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Capture at the accepted shot so later grid_in changes are ignored.
          snap_d  = grid_in;
          row_d   = shoot_row;
          col_d   = shoot_col;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        cnt_d = '0;
        if (!in_range || target == EMPTY_C) begin
          // Nothing to grow: APPLY with an empty mark and zero count
          // republishes the snapshot with pop_count = 0.
          mark_d  = '0;
          state_d = S_APPLY;
        end else begin
          match_d = match_color(snap_q, target);
          mark_d  = N'(1) << idx;
          state_d = S_EXPAND;
        end
      end

      S_EXPAND: begin
        if (next_mark == mark_q) state_d = S_COUNT;
        else                     mark_d  = next_mark;
      end

      S_COUNT: begin
        cnt_d   = popcnt(mark_q);
        state_d = S_APPLY;
      end

      S_APPLY: begin
        if (int'(cnt_q) >= MIN_POP) begin
          grid_d  = clear_cells(snap_q, mark_q);
          pop_d   = cnt_q;
`ifdef BUBBLE_DROP_FLOAT_EN
          state_d = S_ANCHOR;
`else
          state_d = S_DONE;
`endif
        end else begin
          grid_d  = snap_q;
          pop_d   = '0;
          state_d = S_DONE;
        end
      end

`ifdef BUBBLE_DROP_FLOAT_EN
      S_ANCHOR: begin
        // Reuse the EXPAND machinery: match = occupied cells, seed = row 0.
        match_d = ~match_color(grid_q, EMPTY_C);
        mark_d  = match_d & N'({COLS{1'b1}});
        state_d = S_FLOOD;
      end

      S_FLOOD: begin
        if (next_mark == mark_q) begin
          grid_d  = clear_cells(grid_q, match_q & ~mark_q);
          pop_d   = pop_q + popcnt(match_q & ~mark_q);
          state_d = S_DONE;
        end else begin
          mark_d  = next_mark;
        end
      end
`endif

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      // NOTE: the snapshot and mask registers are reset too, so no state leaks across a reset.
      snap_q  <= {N{EMPTY_C}};
      row_q   <= '0;
      col_q   <= '0;
      match_q <= '0;
      mark_q  <= '0;
      cnt_q   <= '0;
      grid_q  <= {N{EMPTY_C}};
      pop_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from pre-edge values.
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      match_q <= match_d;
      mark_q  <= mark_d;
      cnt_q   <= cnt_d;
      grid_q  <= grid_d;
      pop_q   <= pop_d;
    end
  end

  assign grid_out  = grid_q;
  assign pop_count = pop_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule
